// File: rtl/fmpadding_cfg_regs_if.sv
// Write-enable bus from the AXI-Lite write adapter into the padding config bank.
// It carries a single-cycle strobe, a byte address and 32-bit data.
interface fmpadding_cfg_regs_if #(
    parameter int ADDR_BITS = 5
);
    logic                 we;
    logic [ADDR_BITS-1:0] wa;
    logic [31:0]          wd;

    modport master (output we, wa, wd);
    modport slave  (input  we, wa, wd);
endinterface

// File: rtl/fmpadding_cfg_regs.sv
// Padding geometry config bank: shadow registers are written from the bus.
// A validated shadow set is copied atomically into the active registers at a frame boundary.
module fmpadding_cfg_regs #(
    parameter int          ADDR_BITS = 5,
    parameter int          DIM_BITS  = 16,
    parameter int unsigned INIT_XON  = 0,
    parameter int unsigned INIT_XOFF = 0,
    parameter int unsigned INIT_XEND = 0,
    parameter int unsigned INIT_YON  = 0,
    parameter int unsigned INIT_YOFF = 0,
    parameter int unsigned INIT_YEND = 0
) (
    input  logic                ap_clk,
    input  logic                ap_rst_n,
    fmpadding_cfg_regs_if.slave wr,
    input  logic                boundary,
    output logic [DIM_BITS-1:0] xon,
    output logic [DIM_BITS-1:0] xoff,
    output logic [DIM_BITS-1:0] xend,
    output logic [DIM_BITS-1:0] yon,
    output logic [DIM_BITS-1:0] yoff,
    output logic [DIM_BITS-1:0] yend,
    output logic                cfg_update,
    output logic                cfg_err
);
    localparam int NREG = 6;

    logic                     addr_ok;
    logic [2:0]               idx;
    logic                     wr_en;
    logic                     ctrl_wr;
    logic                     commit;
    logic                     set_valid;
    logic                     pending_reg;
    logic                     cfg_update_reg;
    logic                     cfg_err_reg;
    logic [NREG*DIM_BITS-1:0] shadow_flat;
    logic [NREG*DIM_BITS-1:0] active_flat;
    logic                     unused_bits;

    // Addresses above the 32-byte window alias nothing and are dropped.
    generate
        if (ADDR_BITS > 5) begin : g_addr_hi
            assign addr_ok = (wr.wa[ADDR_BITS-1:5] == '0);
        end else begin : g_addr_exact
            assign addr_ok = 1'b1;
        end
    endgenerate

    assign idx         = wr.wa[4:2];
    assign wr_en       = wr.we && addr_ok;
    assign ctrl_wr     = wr_en && (idx == 3'd6);
    assign commit      = boundary && pending_reg;
    assign unused_bits = &{1'b0, wr.wa[1:0], wr.wd};

    assign set_valid =
        (shadow_flat[0*DIM_BITS +: DIM_BITS] <= shadow_flat[1*DIM_BITS +: DIM_BITS]) &&
        (shadow_flat[1*DIM_BITS +: DIM_BITS] <= shadow_flat[2*DIM_BITS +: DIM_BITS]) &&
        (shadow_flat[3*DIM_BITS +: DIM_BITS] <= shadow_flat[4*DIM_BITS +: DIM_BITS]) &&
        (shadow_flat[4*DIM_BITS +: DIM_BITS] <= shadow_flat[5*DIM_BITS +: DIM_BITS]);

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_reg
            localparam int unsigned INIT_RAW =
                (gi == 0) ? INIT_XON  :
                (gi == 1) ? INIT_XOFF :
                (gi == 2) ? INIT_XEND :
                (gi == 3) ? INIT_YON  :
                (gi == 4) ? INIT_YOFF : INIT_YEND;
            localparam logic [DIM_BITS-1:0] INIT_V = DIM_BITS'(INIT_RAW);

            logic [DIM_BITS-1:0] shadow_reg;
            logic [DIM_BITS-1:0] active_reg;

            // Active copies the shadow value held before this edge, so a
            // same-cycle shadow write lands only in shadow.
            always_ff @(posedge ap_clk or negedge ap_rst_n) begin
                if (!ap_rst_n) begin
                    shadow_reg <= INIT_V;
                    active_reg <= INIT_V;
                end else begin
                    if (commit && set_valid) begin
                        active_reg <= shadow_reg;
                    end
                    if (wr_en && (idx == 3'(gi))) begin
                        shadow_reg <= wr.wd[DIM_BITS-1:0];
                    end
                end
            end

            assign shadow_flat[gi*DIM_BITS +: DIM_BITS] = shadow_reg;
            assign active_flat[gi*DIM_BITS +: DIM_BITS] = active_reg;
        end
    endgenerate

    // A commit request arriving with the boundary survives it; an error set beats a clear.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            pending_reg    <= 1'b0;
            cfg_update_reg <= 1'b0;
            cfg_err_reg    <= 1'b0;
        end else begin
            cfg_update_reg <= commit && set_valid;

            if (ctrl_wr && wr.wd[0]) begin
                pending_reg <= 1'b1;
            end else if (commit) begin
                pending_reg <= 1'b0;
            end

            if (commit && !set_valid) begin
                cfg_err_reg <= 1'b1;
            end else if (ctrl_wr && wr.wd[1]) begin
                cfg_err_reg <= 1'b0;
            end
        end
    end

    assign xon        = active_flat[0*DIM_BITS +: DIM_BITS];
    assign xoff       = active_flat[1*DIM_BITS +: DIM_BITS];
    assign xend       = active_flat[2*DIM_BITS +: DIM_BITS];
    assign yon        = active_flat[3*DIM_BITS +: DIM_BITS];
    assign yoff       = active_flat[4*DIM_BITS +: DIM_BITS];
    assign yend       = active_flat[5*DIM_BITS +: DIM_BITS];
    assign cfg_update = cfg_update_reg;
    assign cfg_err    = cfg_err_reg;
endmodule
